// File: rtl/prbs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prbs_pkg : mode encodings, LFSR order/tap constants, controller state enum |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package prbs_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'b00,
    MODE_PRBS15 = 2'b01,
    MODE_PRBS23 = 2'b10,
    MODE_PRBS31 = 2'b11
  } prbs_mode_e;

  localparam int ORDER_PRBS7  = 7;
  localparam int TAP_PRBS7    = 6;
  localparam int ORDER_PRBS15 = 15;
  localparam int TAP_PRBS15   = 14;
  localparam int ORDER_PRBS23 = 23;
  localparam int TAP_PRBS23   = 18;
  localparam int ORDER_PRBS31 = 31;
  localparam int TAP_PRBS31   = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Keeps every LFSR bit above the selected order at zero.
  function automatic logic [30:0] order_mask(input logic [1:0] mode);
    case (mode)
      MODE_PRBS7:  return 31'h0000_007F;
      MODE_PRBS15: return 31'h0000_7FFF;
      MODE_PRBS23: return 31'h007F_FFFF;
      default:     return 31'h7FFF_FFFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prbs_seq_ctrl_if : command inputs and pattern outputs of the sequencer     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface prbs_seq_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [LEN_W-1:0] burst_len;
  logic             inj_en;
  logic [LEN_W-1:0] inj_idx;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] bit_cnt;

  modport master (
    output start, abort, mode, burst_len, inj_en, inj_idx,
    input  bit_out, bit_valid, busy, done, bit_cnt
  );

  modport slave (
    input  start, abort, mode, burst_len, inj_en, inj_idx,
    output bit_out, bit_valid, busy, done, bit_cnt
  );
endinterface
`default_nettype wire

// File: rtl/prbs_lfsr_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prbs_lfsr_core : 31-bit Fibonacci LFSR with seed load, step and mode taps  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module prbs_lfsr_core
  import prbs_pkg::*;
#(
  parameter logic [30:0] SEED = 31'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [1:0] i_mode,
  output logic       o_msb
);

  logic [30:0] r_lfsr;
  logic [30:0] w_mask;
  logic [30:0] w_seed;
  logic [30:0] w_next;
  logic        w_msb;
  logic        w_tap;

  always_comb begin
    w_mask = order_mask(i_mode);
    w_seed = SEED & w_mask;
    // An all-zero state would lock the LFSR, so fall back to 1.
    if (w_seed == '0) w_seed = 31'd1;
    w_msb = 1'b0;
    w_tap = 1'b0;
    case (i_mode)
      MODE_PRBS7:  begin w_msb = r_lfsr[ORDER_PRBS7-1];  w_tap = r_lfsr[TAP_PRBS7-1];  end
      MODE_PRBS15: begin w_msb = r_lfsr[ORDER_PRBS15-1]; w_tap = r_lfsr[TAP_PRBS15-1]; end
      MODE_PRBS23: begin w_msb = r_lfsr[ORDER_PRBS23-1]; w_tap = r_lfsr[TAP_PRBS23-1]; end
      default:     begin w_msb = r_lfsr[ORDER_PRBS31-1]; w_tap = r_lfsr[TAP_PRBS31-1]; end
    endcase
    w_next = {r_lfsr[29:0], w_msb ^ w_tap} & w_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 31'd1;
    end else if (i_load) begin
      r_lfsr <= w_seed;
    end else if (i_step) begin
      r_lfsr <= w_next;
    end
  end

  assign o_msb = w_msb;

endmodule
`default_nettype wire

// File: rtl/prbs_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prbs_seq_ctrl : burst sequencer driving the PRBS LFSR core                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int          LEN_W = 16,
  parameter logic [30:0] SEED  = 31'd1
) (
  input  logic           clk,
  input  logic           rst_n,
  prbs_seq_ctrl_if.slave bus
);

  localparam logic [LEN_W-1:0] C_ONE = LEN_W'(1);

  state_e           r_state;
  state_e           w_state_next;
  logic [1:0]       r_mode;
  logic             r_inj_en;
  logic [LEN_W-1:0] r_burst_len;
  logic [LEN_W-1:0] r_inj_idx;
  logic [LEN_W-1:0] r_bit_cnt;
  logic             w_lfsr_msb;
  logic             w_lfsr_load;
  logic             w_lfsr_step;
  logic             w_last_bit;
  logic             w_inj_hit;

  assign w_last_bit  = (r_burst_len != '0) && (r_bit_cnt == r_burst_len - C_ONE);
  assign w_inj_hit   = r_inj_en && (r_bit_cnt == r_inj_idx);
  assign w_lfsr_load = (r_state == ST_SEED);
  assign w_lfsr_step = (r_state == ST_RUN);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // abort wins over normal termination on the final bit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_SEED;
      ST_SEED: w_state_next = bus.abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (bus.abort)       w_state_next = ST_IDLE;
        else if (w_last_bit) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.bit_out   = 1'b0;
    bus.bit_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      ST_SEED: bus.busy = 1'b1;
      ST_RUN: begin
        bus.busy      = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_out   = w_lfsr_msb ^ w_inj_hit;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_mode      <= '0;
      r_inj_en    <= 1'b0;
      r_burst_len <= '0;
      r_inj_idx   <= '0;
    end else if (r_state == ST_IDLE && bus.start) begin
      r_mode      <= bus.mode;
      r_inj_en    <= bus.inj_en;
      r_burst_len <= bus.burst_len;
      r_inj_idx   <= bus.inj_idx;
    end
  end

  // Free-running wrap in continuous mode comes from the natural counter overflow.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_bit_cnt <= '0;
    end else if (r_state == ST_SEED) begin
      r_bit_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_bit_cnt <= r_bit_cnt + C_ONE;
    end
  end

  assign bus.bit_cnt = r_bit_cnt;

  prbs_lfsr_core #(
    .SEED (SEED)
  ) u_lfsr_core (
    .clk    (clk),
    .rst    (rst_n),
    .i_load (w_lfsr_load),
    .i_step (w_lfsr_step),
    .i_mode (r_mode),
    .o_msb  (w_lfsr_msb)
  );

endmodule
`default_nettype wire

// File: tb/tb_prbs_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prbs_seq_ctrl : directed self-checking bench for prbs_seq_ctrl          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_prbs_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_failures;
  logic ref_bits [0:255];

  prbs_seq_ctrl_if #(.LEN_W(16)) bus ();

  prbs_seq_ctrl #(
    .LEN_W (16),
    .SEED  (31'd1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output recurrence o[k] = o[k-n] ^ o[k-t] of x^n + x^t + 1, seeded 0..01.
  task automatic gen_ref(input logic [1:0] m);
    int n;
    int t;
    case (m)
      2'b00:   begin n = 7;  t = 6;  end
      2'b01:   begin n = 15; t = 14; end
      2'b10:   begin n = 23; t = 18; end
      default: begin n = 31; t = 28; end
    endcase
    for (int k = 0; k < 256; k++) begin
      if (k < n) ref_bits[k] = (k == n - 1);
      else       ref_bits[k] = ref_bits[k-n] ^ ref_bits[k-t];
    end
  endtask

  task automatic run_burst(input logic [1:0] m, input int len, input logic ie,
                           input int ii, input int poke, input string tag,
                           output logic [255:0] got);
    logic exp_bit;
    gen_ref(m);
    got           = '0;
    bus.mode      = m;
    bus.burst_len = 16'(len);
    bus.inj_en    = ie;
    bus.inj_idx   = 16'(ii);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.mode      = ~m;
    bus.burst_len = 16'(len + 3);
    bus.inj_en    = ~ie;
    bus.inj_idx   = 16'(ii + 1);
    check_eq({tag, "_seed_vbd"}, {bus.bit_valid, bus.busy, bus.done}, 3'b010);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      bus.start = (k == poke);
      exp_bit   = ref_bits[k] ^ (ie && (k == ii));
      check_eq($sformatf("%s_vbd%0d", tag, k), {bus.bit_valid, bus.busy, bus.done}, 3'b110);
      check_eq($sformatf("%s_cnt%0d", tag, k), bus.bit_cnt, 64'(k));
      check_eq($sformatf("%s_bit%0d", tag, k), bus.bit_out, exp_bit);
      got[k] = bus.bit_out;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_done_vbd"}, {bus.bit_valid, bus.busy, bus.done}, 3'b001);
    check_eq({tag, "_done_bit"}, bus.bit_out, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq({tag, "_idle_vbd"}, {bus.bit_valid, bus.busy, bus.done}, 3'b000);
  endtask

  initial begin
    logic [255:0] got;
    int           errs;
    logic [15:0]  exp_cnt;
    logic         exp_bit;

    n_asserts     = 0;
    n_failures    = 0;
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.mode      = 2'b00;
    bus.burst_len = '0;
    bus.inj_en    = 1'b0;
    bus.inj_idx   = '0;

    repeat (2) @(posedge clk); #1;
    check_eq("rst_vbd", {bus.bit_valid, bus.busy, bus.done}, 3'b000);
    check_eq("rst_bit", bus.bit_out, 1'b0);
    check_eq("rst_cnt", bus.bit_cnt, 16'd0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_idle", {bus.bit_valid, bus.busy, bus.done}, 3'b000);

    run_burst(2'b00, 7, 1'b0, 0, -1, "p7", got);
    check_eq("p7_vector", got[6:0], 7'b1000000);

    run_burst(2'b11, 40, 1'b0, 0, -1, "p31", got);
    check_eq("p31_vector", got[39:0], 40'h00_4000_0000);

    run_burst(2'b01, 100, 1'b1, 50, 60, "p15inj", got);

    run_burst(2'b10, 30, 1'b1, 30, -1, "p23noinj", got);
    check_eq("p23_vector", got[29:0], 30'h0040_0000);

    // Continuous PRBS7 stream with a wrap-repeating injection at index 5.
    gen_ref(2'b00);
    bus.mode      = 2'b00;
    bus.burst_len = 16'd0;
    bus.inj_en    = 1'b1;
    bus.inj_idx   = 16'd5;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    errs      = 0;
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk); #1;
      exp_cnt = 16'(k % 65536);
      exp_bit = ref_bits[k % 127] ^ (exp_cnt == 16'd5);
      if (bus.bit_cnt !== exp_cnt || bus.bit_out !== exp_bit || bus.bit_valid !== 1'b1 ||
          bus.busy !== 1'b1 || bus.done !== 1'b0) errs++;
      if (k == 65535) check_eq("cont_cnt_top", bus.bit_cnt, 16'hFFFF);
      if (k == 65536) check_eq("cont_cnt_wrap", bus.bit_cnt, 16'h0000);
      if (k == 65541) check_eq("cont_inj_rewrap", bus.bit_out, ref_bits[65541 % 127] ^ 1'b1);
    end
    check_eq("cont_stream_errs", errs, 0);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_eq("cont_abort_vbd", {bus.bit_valid, bus.busy, bus.done}, 3'b000);
    @(posedge clk); #1;
    check_eq("cont_abort_nodone", {bus.bit_valid, bus.busy, bus.done}, 3'b000);

    // abort on the last bit of a finite burst suppresses done.
    bus.mode      = 2'b00;
    bus.burst_len = 16'd5;
    bus.inj_en    = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 4) bus.abort = 1'b1;
    end
    check_eq("abort_last_cnt", bus.bit_cnt, 16'd4);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_eq("abort_prio_vbd", {bus.bit_valid, bus.busy, bus.done}, 3'b000);

    // Asynchronous reset in the middle of a burst.
    bus.mode      = 2'b01;
    bus.burst_len = 16'd50;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk); #1;
    check_eq("midrst_pre_cnt", bus.bit_cnt, 16'd9);
    #2 rst_n = 1'b1;
    #1;
    check_eq("midrst_vbd", {bus.bit_valid, bus.busy, bus.done}, 3'b000);
    check_eq("midrst_bit", bus.bit_out, 1'b0);
    check_eq("midrst_cnt", bus.bit_cnt, 16'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_after_vbd", {bus.bit_valid, bus.busy, bus.done}, 3'b000);

    run_burst(2'b00, 3, 1'b0, 0, 1, "recover", got);
    check_eq("recover_vector", got[2:0], 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs_seq_ctrl.md
# prbs_seq_ctrl

Burst sequencer and configuration controller for the on-chip PRBS pattern generator. It accepts a start command with a polynomial selection, a burst length and an optional single-bit error-injection point. It then seeds and steps a polynomial-selectable LFSR core for exactly the requested number of bits, or continuously, and reports completion. It sits between the pin-level control inputs and the serial pattern output.

## Interface
Parameters:
- LEN_W, 16, width of burst length, bit counter and injection index
- SEED, 31'd1, LFSR load value, masked to the selected polynomial order

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-high reset (high = reset, despite the name)
- start  in  1  command strobe; sampled only in IDLE
- abort  in  1  terminates any active burst; sampled in SEED and RUN
- mode  in  2  polynomial: 00 PRBS7 (x^7+x^6+1), 01 PRBS15 (x^15+x^14+1), 10 PRBS23 (x^23+x^18+1), 11 PRBS31 (x^31+x^28+1)
- burst_len  in  LEN_W  bits per burst; 0 = continuous
- inj_en  in  1  enable single-bit error injection
- inj_idx  in  LEN_W  bit index (0-based) to invert
- bit_out  out  1  pattern bit; 0 whenever bit_valid = 0
- bit_valid  out  1  high for every cycle a pattern bit is presented
- busy  out  1  high in SEED and RUN
- done  out  1  one-cycle pulse when a finite burst completes
- bit_cnt  out  LEN_W  index of the current bit

## Operation
- FSM states: IDLE, SEED, RUN, DONE.
- IDLE: If start = 1, latch mode, burst_len, inj_en and inj_idx, then go to SEED. Otherwise stay in IDLE.
- SEED (1 cycle): Load lfsr with SEED masked to order n; if the masked value is 0, load 1. Clear bit_cnt. Go to RUN.
- RUN, every cycle:
  - bit_out = lfsr[n-1] ^ (inj_en_l && bit_cnt == inj_idx_l).
  - lfsr shifts left with lfsr[0] <= lfsr[n-1] ^ lfsr[t-1], where t is the second tap.
  - bit_cnt increments.
- RUN termination: if burst_len_l != 0 and bit_cnt == burst_len_l - 1, go to DONE after this bit.
- Continuous mode: bit_cnt wraps from 2^LEN_W-1 to 0. Injection repeats on each wrap at inj_idx. The burst runs until abort.
- DONE (1 cycle): done = 1, bit_valid = 0. Go to IDLE.
- abort in SEED or RUN: go to IDLE on the next edge. No done pulse. abort takes priority over normal termination in the same cycle.
- start while busy or in DONE is ignored and not queued.
- Injection affects bit_out only; the LFSR sequence is not perturbed.
- inj_idx_l ≥ burst_len_l in finite mode means no bit is inverted.
- LFSR bits above order n are held at 0.

## Timing
- Reset values: state IDLE, lfsr = 1, bit_cnt = 0, bit_out = 0, bit_valid = 0, busy = 0, done = 0.
- Asynchronous reset mid-burst returns to IDLE immediately with no done pulse.
- All outputs are decoded from registers only; there is no combinational path from any input.
- Sequence from start:
  - start sampled at edge E0.
  - SEED during cycle E0–E1; busy = 1.
  - First valid bit during cycle E1–E2.
  - Bit k is presented during cycle E(k+1)–E(k+2).
- Finite burst of L bits: bit_valid is high for exactly L consecutive cycles. done follows in the next cycle. busy drops with done.
- Back-to-back bursts: the earliest next start is sampled in the cycle after DONE, i.e. 2 idle cycles between bursts.

## Structure
- Package prbs_pkg holds:
  - mode encodings;
  - per-mode order and second-tap constants (7/6, 15/14, 23/18, 31/28);
  - the state enum.
- Sub-module prbs_lfsr_core: 31-bit register with load, enable and mode-selected taps. The controller owns the FSM, counter, latching and injection.

## Test plan
- mode = 00, burst_len = 7, SEED = 1, no injection → bits 0000001, bit_valid high 7 cycles, done pulse on the 8th cycle.
- mode = 11, burst_len = 40 → bits 0..29 are 0 and bit 30 is 1; this must match an independent reference PRBS31 model over all 40 bits.
- mode = 01, burst_len = 100, inj_en = 1, inj_idx = 50 → output equals the reference model except bit 50, which is inverted.
- burst_len = 0, abort asserted after 70000 cycles → bit_cnt wraps to 0 at 65536, continuous stream, no done, busy low one cycle after abort.
- Mid-burst rst_n pulse, and start asserted during RUN → immediate return to reset values; the mid-burst start has no effect.
